// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Sequential ALU with a valid/ready handshake on input and output.
//             Add, sub and the logic ops finish in one cycle. Multiply
//             (shift-add) and divide (restoring) take WIDTH iterations, one
//             bit per cycle. The result and its flags are registered together
//             and held until the consumer takes them. At most one result is
//             in flight at a time.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          rising-edge clock
//    rst          asynchronous, active-high reset
//    in_valid     operation offered
//    in_ready     block can accept an operation (IDLE only)
//    firstInput   operand A
//    secondInput  operand B
//    operation    opcode
//    out_valid    result held and valid
//    out_ready    consumer takes the result
//    ALU_Out      result
//    CarryOut     add carry-out / sub borrow (A < B)
//    Zero         ALU_Out == 0
//    Overflow     mul: upper WIDTH bits of the full product are nonzero
//    DivZero      div with B == 0; ALU_Out is forced to all-ones
// ============================================================================
module alu_seq #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] firstInput,
   input  logic [WIDTH-1:0] secondInput,
   input  logic [3:0]       operation,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALU_Out,
   output logic             CarryOut,
   output logic             Zero,
   output logic             Overflow,
   output logic             DivZero
);

   localparam logic [3:0] c_op_sub  = 4'b0001;
   localparam logic [3:0] c_op_mul  = 4'b0010;
   localparam logic [3:0] c_op_div  = 4'b0011;
   localparam logic [3:0] c_op_pass = 4'b0111;
   localparam logic [3:0] c_op_and  = 4'b1000;
   localparam logic [3:0] c_op_or   = 4'b1001;
   localparam logic [3:0] c_op_xor  = 4'b1010;
   localparam logic [3:0] c_op_nor  = 4'b1100;

   localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [WIDTH-1:0]     r_opa;     // multiplicand (mul) or divisor (div)
   logic                 r_is_div;
   logic [2*WIDTH-1:0]   r_work;    // {high, low}: product or {remainder, quotient}
   logic [CNT_W-1:0]     r_cnt;

   // ---------------------------------------------------------------------
   // Single-cycle datapath, evaluated straight off the input ports so the
   // result can be registered on the accept edge.
   // ---------------------------------------------------------------------
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_res;
   logic             w_carry;
   logic             w_multi;

   always_comb begin
      w_sum   = {1'b0, firstInput} + {1'b0, secondInput};
      w_res   = w_sum[WIDTH-1:0];
      w_carry = w_sum[WIDTH];
      case (operation)
         c_op_sub: begin
            w_res   = firstInput - secondInput;
            w_carry = (firstInput < secondInput);
         end
         c_op_and:  begin w_res = firstInput & secondInput;    w_carry = 1'b0; end
         c_op_or:   begin w_res = firstInput | secondInput;    w_carry = 1'b0; end
         c_op_xor:  begin w_res = firstInput ^ secondInput;    w_carry = 1'b0; end
         c_op_pass: begin w_res = secondInput;                 w_carry = 1'b0; end
         c_op_nor:  begin w_res = ~(firstInput | secondInput); w_carry = 1'b0; end
         default:   ; // add, including every unassigned opcode
      endcase
   end

   assign w_multi = (operation == c_op_mul) || (operation == c_op_div);

   // ---------------------------------------------------------------------
   // One iteration of the multi-cycle ops.
   // Mul: add the multiplicand into the high half when the current
   //      multiplier bit (low half, bit 0) is set, then shift the whole
   //      register right, keeping the add's carry as the new top bit.
   // Div: shift {remainder, quotient} left by one; if the partial remainder
   //      reaches the divisor, subtract it and shift in a quotient 1.
   //      When the subtraction succeeds the difference is below 2^WIDTH,
   //      so only its low WIDTH bits are kept.
   // ---------------------------------------------------------------------
   logic [WIDTH:0]       w_hi_sum;
   logic [2*WIDTH-1:0]   w_mul_next;
   logic [WIDTH:0]       w_shift;
   logic                 w_ge;
   logic [WIDTH-1:0]     w_diff;
   logic [2*WIDTH-1:0]   w_div_next;
   logic [2*WIDTH-1:0]   w_next;
   logic                 w_divz;
   logic [WIDTH-1:0]     w_iter_res;

   always_comb begin
      w_hi_sum   = {1'b0, r_work[2*WIDTH-1:WIDTH]}
                 + (r_work[0] ? {1'b0, r_opa} : {(WIDTH+1){1'b0}});
      w_mul_next = {w_hi_sum, r_work[WIDTH-1:1]};

      w_shift    = r_work[2*WIDTH-1:WIDTH-1];
      w_ge       = (w_shift >= {1'b0, r_opa});
      w_diff     = w_shift[WIDTH-1:0] - r_opa;
      w_div_next = {(w_ge ? w_diff : w_shift[WIDTH-1:0]), r_work[WIDTH-2:0], w_ge};

      w_next     = r_is_div ? w_div_next : w_mul_next;
      w_divz     = r_is_div && (r_opa == '0);
      w_iter_res = w_divz ? {WIDTH{1'b1}} : w_next[WIDTH-1:0];
   end

   // ---------------------------------------------------------------------
   // Control FSM with registered handshake outputs, result and flags.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         ALU_Out   <= '0;
         CarryOut  <= 1'b0;
         Zero      <= 1'b0;
         Overflow  <= 1'b0;
         DivZero   <= 1'b0;
         r_cnt     <= '0;
         r_opa     <= '0;
         r_is_div  <= 1'b0;
         r_work    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  if (w_multi) begin
                     r_state  <= S_BUSY;
                     r_cnt    <= '0;
                     r_is_div <= (operation == c_op_div);
                     if (operation == c_op_div) begin
                        r_opa  <= secondInput;
                        r_work <= {{WIDTH{1'b0}}, firstInput};
                     end else begin
                        r_opa  <= firstInput;
                        r_work <= {{WIDTH{1'b0}}, secondInput};
                     end
                  end else begin
                     r_state   <= S_DONE;
                     out_valid <= 1'b1;
                     ALU_Out   <= w_res;
                     CarryOut  <= w_carry;
                     Zero      <= (w_res == '0);
                     Overflow  <= 1'b0;
                     DivZero   <= 1'b0;
                  end
               end
            end

            S_BUSY: begin
               r_work <= w_next;
               r_cnt  <= r_cnt + CNT_W'(1);
               if (r_cnt == c_last) begin
                  r_state   <= S_DONE;
                  r_cnt     <= '0;
                  out_valid <= 1'b1;
                  ALU_Out   <= w_iter_res;
                  CarryOut  <= 1'b0;
                  Zero      <= (w_iter_res == '0);
                  Overflow  <= !r_is_div && (w_next[2*WIDTH-1:WIDTH] != '0);
                  DivZero   <= w_divz;
               end
            end

            S_DONE: begin
               if (out_ready) begin
                  r_state   <= S_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end

            default: begin
               r_state   <= S_IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Self-checking bench for alu_seq at WIDTH=8: a table of directed
//             vectors, randomized operations against a behavioural model,
//             and hand-written backpressure and mid-operation reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] firstInput = '0;
   logic [W-1:0] secondInput = '0;
   logic [3:0]   operation = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] ALU_Out;
   logic         CarryOut, Zero, Overflow, DivZero;

   int total = 0;
   int bad   = 0;

   alu_seq #(.WIDTH(W), .CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .firstInput (firstInput),
      .secondInput(secondInput),
      .operation  (operation),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ALU_Out    (ALU_Out),
      .CarryOut   (CarryOut),
      .Zero       (Zero),
      .Overflow   (Overflow),
      .DivZero    (DivZero)
   );

   always #5 clk = ~clk;

   // flags packed as {CarryOut, Zero, Overflow, DivZero}
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0]   op;
      logic [W-1:0] res;
      logic [3:0]   flags;
      int           lat;
   } vec_t;

   vec_t vecs[16];
   vec_t post[3];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Behavioural reference: the opcode table applied with plain arithmetic.
   function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [3:0] op, output logic [W-1:0] res,
                                     output logic [3:0] flags, output int lat);
      longint full;
      logic c, o, d;
      c = 0; o = 0; d = 0; lat = 1;
      case (op)
         4'b0001: begin res = a - b; c = (a < b); end
         4'b0010: begin
            full = longint'(a) * longint'(b);
            res  = W'(full);
            o    = (full > ((longint'(1) << W) - 1));
            lat  = W + 1;
         end
         4'b0011: begin
            lat = W + 1;
            if (b == 0) begin res = '1; d = 1; end
            else res = a / b;
         end
         4'b1000: res = a & b;
         4'b1001: res = a | b;
         4'b1010: res = a ^ b;
         4'b0111: res = b;
         4'b1100: res = ~(a | b);
         default: begin
            full = longint'(a) + longint'(b);
            res  = W'(full);
            c    = (full >= (longint'(1) << W));
         end
      endcase
      flags = {c, (res == 0), o, d};
   endfunction

   task automatic scramble();
      in_valid    = 1'($urandom);
      firstInput  = W'($urandom);
      secondInput = W'($urandom);
      operation   = 4'($urandom);
   endtask

   // Offer one op, count edges from the accept edge to out_valid, then drain.
   // Operand/valid ports are randomized while the op is in flight.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                         output logic [W-1:0] res, output logic [3:0] flags,
                         output int lat, output logic ready_seen, output logic [1:0] after);
      @(negedge clk);
      firstInput = a; secondInput = b; operation = op; in_valid = 1'b1;
      @(posedge clk); #1;
      scramble();
      lat = 1;
      ready_seen = 1'b0;
      while (!out_valid && lat < 40) begin
         if (in_ready) ready_seen = 1'b1;
         @(posedge clk); #1;
         scramble();
         lat++;
      end
      if (in_ready) ready_seen = 1'b1;
      res   = ALU_Out;
      flags = {CarryOut, Zero, Overflow, DivZero};
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      after = {out_valid, in_ready};
   endtask

   task automatic check_vec(input string tag, input vec_t v);
      logic [W-1:0] res;
      logic [3:0]   flags;
      int           lat;
      logic         rs;
      logic [1:0]   after;
      run_op(v.a, v.b, v.op, res, flags, lat, rs, after);
      chk({tag, " res"},   res,   v.res);
      chk({tag, " flags"}, flags, v.flags);
      chk({tag, " lat"},   lat,   v.lat);
      chk({tag, " ready_low"}, rs, 0);
      chk({tag, " release"}, after, 2'b01);
   endtask

   initial begin
      vecs[0]  = '{8'hF0, 8'h20, 4'b0000, 8'h10, 4'b1000, 1};
      vecs[1]  = '{8'h05, 8'h05, 4'b0001, 8'h00, 4'b0100, 1};
      vecs[2]  = '{8'h03, 8'h05, 4'b0001, 8'hFE, 4'b1000, 1};
      vecs[3]  = '{8'h10, 8'h11, 4'b0010, 8'h10, 4'b0010, 9};
      vecs[4]  = '{8'h07, 8'h06, 4'b0010, 8'h2A, 4'b0000, 9};
      vecs[5]  = '{8'h64, 8'h07, 4'b0011, 8'h0E, 4'b0000, 9};
      vecs[6]  = '{8'h64, 8'h00, 4'b0011, 8'hFF, 4'b0001, 9};
      vecs[7]  = '{8'hF0, 8'h3C, 4'b1000, 8'h30, 4'b0000, 1};
      vecs[8]  = '{8'hF0, 8'h0C, 4'b1001, 8'hFC, 4'b0000, 1};
      vecs[9]  = '{8'h12, 8'h34, 4'b0111, 8'h34, 4'b0000, 1};
      vecs[10] = '{8'h0F, 8'hF0, 4'b1100, 8'h00, 4'b0100, 1};
      vecs[11] = '{8'hFF, 8'h01, 4'b0000, 8'h00, 4'b1100, 1};
      vecs[12] = '{8'hFF, 8'hFF, 4'b0010, 8'h01, 4'b0010, 9};
      vecs[13] = '{8'h05, 8'h09, 4'b0011, 8'h00, 4'b0100, 9};
      vecs[14] = '{8'hFF, 8'h01, 4'b0011, 8'hFF, 4'b0000, 9};
      vecs[15] = '{8'h7F, 8'h01, 4'b0100, 8'h80, 4'b0000, 1};

      post[0]  = '{8'h01, 8'h01, 4'b0000, 8'h02, 4'b0000, 1};
      post[1]  = '{8'h0F, 8'hF0, 4'b1100, 8'h00, 4'b0100, 1};
      post[2]  = '{8'h01, 8'h02, 4'b0101, 8'h03, 4'b0000, 1};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid", out_valid, 0);
      chk("reset ALU_Out", ALU_Out, 0);
      chk("reset flags", {CarryOut, Zero, Overflow, DivZero}, 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed table
      for (int i = 0; i < 16; i++) check_vec($sformatf("vec%0d", i), vecs[i]);

      // Randomized ops against the model
      for (int i = 0; i < 40; i++) begin
         vec_t r;
         r.a  = W'($urandom);
         r.b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         r.op = 4'($urandom);
         ref_model(r.a, r.b, r.op, r.res, r.flags, r.lat);
         check_vec($sformatf("rnd%0d op%0h", i, r.op), r);
      end

      // Backpressure: result held while out_ready stays low
      @(negedge clk);
      firstInput = 8'hAA; secondInput = 8'h0F; operation = 4'b1010; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp out_valid at accept+1", out_valid, 1);
      for (int k = 0; k < 5; k++) begin
         in_valid    = k[0];
         firstInput  = W'($urandom);
         secondInput = W'($urandom);
         operation   = 4'($urandom);
         @(posedge clk); #1;
         chk($sformatf("bp hold res %0d", k), ALU_Out, 8'hA5);
         chk($sformatf("bp hold hs %0d", k), {out_valid, in_ready}, 2'b10);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp release", {out_valid, in_ready}, 2'b01);
      @(posedge clk); #1;
      chk("bp no ghost accept", {out_valid, in_ready}, 2'b01);

      // Asynchronous reset during cycle 4 of a multiply
      @(negedge clk);
      firstInput = 8'h10; secondInput = 8'h11; operation = 4'b0010; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst out_valid", out_valid, 0);
      chk("midrst ALU_Out", ALU_Out, 0);
      chk("midrst in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("midrst no result", {out_valid, in_ready}, 2'b01);

      for (int i = 0; i < 3; i++) check_vec($sformatf("post%0d", i), post[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
